sysid_boot_checker: RTL and testbench

- Avalon-MM read master that sequences the 2-word system-ID control slave after reset, or on request.
- Reads word 0 (system ID), then word 1 (build timestamp), and compares each against the expected values.
- Reports pass or fail to the boot/reset supervisor, with retry and timeout handling.
- Sits between the system-ID slave port and the boot-release logic; the CPU is held until done=1.

---
 rtl/sysid_ctrl_pkg.sv | 19 +
 rtl/sysid_rd_latency.sv | 32 +++
 rtl/sysid_boot_checker.sv | 158 +++++++++++++++
 tb/tb_sysid_boot_checker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_ctrl_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_ctrl_pkg;

  localparam int WORD_W = 32;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    S_LAUNCH,
    S_RD_ID,
    S_LAT_ID,
    S_RD_TS,
    S_LAT_TS,
    S_CHECK,
    S_DONE
  } state_t;

endpackage

// File: rtl/sysid_rd_latency.sv
// Delays the read-acceptance pulse by LATENCY cycles so it lines up with
// valid readdata; with LATENCY=0 the strobe is the acceptance itself.
module sysid_rd_latency #(
  parameter int unsigned LATENCY = 0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic accept,
  output logic strobe
);

  localparam int unsigned PIPE_W = (LATENCY == 0) ? 1 : LATENCY;

  logic [PIPE_W-1:0] valid_pipe;

  // Shift the acceptance pulse one stage per cycle.
  // NOTE: non-blocking assignments let each stage take its neighbour's pre-edge value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: this pipe is reset on purpose; a stale bit would fire a capture strobe after reset.
      valid_pipe <= '0;
    end else begin
      valid_pipe[0] <= accept;
      for (int i = 1; i < int'(PIPE_W); i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
      end
    end
  end

  assign strobe = (LATENCY == 0) ? accept : valid_pipe[PIPE_W-1];

endmodule

// File: rtl/sysid_boot_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp after
// reset (or on start), compares them with the expected values, retries on a
// mismatch, abandons a stalled read, and reports the verdict to the boot
// supervisor through done/pass and sticky diagnostic flags.
module sysid_boot_checker
  import sysid_ctrl_pkg::*;
#(
  parameter logic [WORD_W-1:0] EXPECTED_ID    = 32'h1234_5678,
  parameter logic [WORD_W-1:0] EXPECTED_TS    = 32'h5446_294C,
  parameter int unsigned       READ_LATENCY   = 0,
  parameter int unsigned       MAX_RETRIES    = 2,
  parameter int unsigned       TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [WORD_W-1:0] avm_readdata,
  output logic [WORD_W-1:0] id_value,
  output logic [WORD_W-1:0] ts_value,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              mismatch_id,
  output logic              mismatch_ts,
  output logic              timeout
);

  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam int WAIT_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  state_t             state;
  state_t             state_next;
  logic [RETRY_W-1:0] retry_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               accept;
  logic               strobe;
  logic               stall_expired;
  logic               words_ok;
  logic               retry_left;

  // Read request is a pure decode of state, so it falls with reset asynchronously.
  assign avm_read      = (state == S_RD_ID) || (state == S_RD_TS);
  assign avm_address   = (state == S_RD_TS) ? ADDR_TS : ADDR_ID;
  assign done          = (state == S_DONE);
  assign accept        = avm_read && !avm_waitrequest;
  // The last tolerated stall cycle: read is dropped on the following cycle.
  assign stall_expired = avm_read && avm_waitrequest &&
                         (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign words_ok      = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
  assign retry_left    = (retry_cnt < RETRY_W'(MAX_RETRIES));

  sysid_rd_latency #(
    .LATENCY (READ_LATENCY)
  ) u_rd_latency (
    .clock   (clock),
    .reset_n (reset_n),
    .accept  (accept),
    .strobe  (strobe)
  );

  // Next-state decode for the read/compare sequence.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      S_LAUNCH: state_next = S_RD_ID;
      S_RD_ID: begin
        if (stall_expired)  state_next = S_DONE;
        else if (accept)    state_next = (READ_LATENCY == 0) ? S_RD_TS : S_LAT_ID;
      end
      S_LAT_ID: if (strobe) state_next = S_RD_TS;
      S_RD_TS: begin
        if (stall_expired)  state_next = S_DONE;
        else if (accept)    state_next = (READ_LATENCY == 0) ? S_CHECK : S_LAT_TS;
      end
      S_LAT_TS: if (strobe) state_next = S_CHECK;
      S_CHECK: begin
        if (words_ok)        state_next = S_DONE;
        else if (retry_left) state_next = S_RD_ID;
        else                 state_next = S_DONE;
      end
      S_DONE:   if (start)  state_next = S_LAUNCH;
      default:              state_next = S_LAUNCH;
    endcase
  end

  // State register; reset parks in LAUNCH so release auto-starts the check.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_LAUNCH;
    else          state <= state_next;
  end

  // Consecutive stall cycles of the read currently on the bus.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                         wait_cnt <= '0;
    else if (state == S_LAUNCH || accept) wait_cnt <= '0;
    else if (avm_read && avm_waitrequest) wait_cnt <= wait_cnt + 1'b1;
  end

  // Re-sequences used after a mismatch; cleared by an accepted start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                       retry_cnt <= '0;
    else if (state == S_DONE && start)                  retry_cnt <= '0;
    else if (state == S_CHECK && !words_ok && retry_left) retry_cnt <= retry_cnt + 1'b1;
  end

  // Capture each word on its strobe; values persist until the next capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_value <= '0;
      ts_value <= '0;
    end else begin
      if (strobe && (state == S_RD_ID || state == S_LAT_ID)) id_value <= avm_readdata;
      if (strobe && (state == S_RD_TS || state == S_LAT_TS)) ts_value <= avm_readdata;
    end
  end

  // Verdict and sticky diagnostic flags for the current run.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      pass        <= 1'b0;
      mismatch_id <= 1'b0;
      mismatch_ts <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      busy <= (state_next != S_DONE);
      case (state)
        S_LAUNCH: begin
          mismatch_id <= 1'b0;
          mismatch_ts <= 1'b0;
          timeout     <= 1'b0;
        end
        S_RD_ID, S_RD_TS: begin
          if (stall_expired) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
          end
        end
        S_CHECK: begin
          if (words_ok) begin
            pass <= 1'b1;
          end else if (!retry_left) begin
            mismatch_id <= (id_value != EXPECTED_ID);
            mismatch_ts <= (ts_value != EXPECTED_TS);
            pass        <= 1'b0;
          end
        end
        S_DONE: if (start) pass <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Runs two checkers side by side (read latency 0 and 2) against behavioural
// Avalon slaves and compares the outcome of each run with a run-level model.
module tb_sysid_boot_checker;

  localparam int          N           = 2;
  localparam logic [31:0] EXP_ID      = 32'h1234_5678;
  localparam logic [31:0] EXP_TS      = 32'h5446_294C;
  localparam int          MAX_RETRIES = 2;
  localparam int          TIMEOUT     = 255;
  localparam int          BUDGET      = 2000;

  logic clock = 1'b0;
  logic reset_n;
  logic start;

  always #5 clock = ~clock;

  // Slave behaviour shared by both instances.
  int          stall_len  = 0;
  logic [31:0] word_id    = EXP_ID;
  logic [31:0] word_ts    = EXP_TS;
  logic        clr_stats  = 1'b0;

  wire        avm_address     [N];
  wire        avm_read        [N];
  wire        avm_waitrequest [N];
  wire [31:0] avm_readdata    [N];
  wire [31:0] id_value        [N];
  wire [31:0] ts_value        [N];
  wire        busy            [N];
  wire        done            [N];
  wire        pass            [N];
  wire        mismatch_id     [N];
  wire        mismatch_ts     [N];
  wire        timeout         [N];
  wire [31:0] rd_id_a         [N];
  wire [31:0] rd_ts_a         [N];
  wire [31:0] read_high_a     [N];
  wire        first_seen_a    [N];
  wire        first_addr_a    [N];
  wire        unstable_a      [N];

  logic [31:0] cap_id [N];
  logic [31:0] cap_ts [N];

  int tests  = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_inst
    sysid_boot_checker #(
      .READ_LATENCY (2 * g)
    ) u_dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .start           (start),
      .avm_address     (avm_address[g]),
      .avm_read        (avm_read[g]),
      .avm_waitrequest (avm_waitrequest[g]),
      .avm_readdata    (avm_readdata[g]),
      .id_value        (id_value[g]),
      .ts_value        (ts_value[g]),
      .busy            (busy[g]),
      .done            (done[g]),
      .pass            (pass[g]),
      .mismatch_id     (mismatch_id[g]),
      .mismatch_ts     (mismatch_ts[g]),
      .timeout         (timeout[g])
    );

    int          stall_cnt  = 0;
    logic [31:0] rd_id      = '0;
    logic [31:0] rd_ts      = '0;
    logic [31:0] read_high  = '0;
    logic        first_seen = 1'b0;
    logic        first_addr = 1'b0;
    logic        unstable   = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_addr  = 1'b0;
    logic [1:0]  pv         = '0;
    logic        pa0        = 1'b0;
    logic        pa1        = 1'b0;
    logic [31:0] garbage    = '0;

    wire acc = avm_read[g] && !avm_waitrequest[g];

    assign avm_waitrequest[g] = avm_read[g] && (stall_cnt < stall_len);
    // Outside the valid data cycle the slave drives noise.
    assign avm_readdata[g] = (g == 0) ? (acc   ? (avm_address[g] ? word_ts : word_id) : garbage)
                                      : (pv[1] ? (pa1 ? word_ts : word_id) : garbage);
    assign rd_id_a[g]      = rd_id;
    assign rd_ts_a[g]      = rd_ts;
    assign read_high_a[g]  = read_high;
    assign first_seen_a[g] = first_seen;
    assign first_addr_a[g] = first_addr;
    assign unstable_a[g]   = unstable;

    always @(posedge clock) begin
      garbage    <= $urandom;
      pv         <= {pv[0], acc};
      pa0        <= avm_address[g];
      pa1        <= pa0;
      prev_stall <= reset_n && avm_read[g] && avm_waitrequest[g];
      prev_addr  <= avm_address[g];
      if (clr_stats || !reset_n) stall_cnt <= 0;
      else if (acc)              stall_cnt <= 0;
      else if (avm_read[g] && avm_waitrequest[g]) stall_cnt <= stall_cnt + 1;
      if (clr_stats) begin
        rd_id      <= '0;
        rd_ts      <= '0;
        read_high  <= '0;
        first_seen <= 1'b0;
        unstable   <= 1'b0;
      end else if (reset_n) begin
        if (acc && avm_address[g])  rd_ts <= rd_ts + 1;
        if (acc && !avm_address[g]) rd_id <= rd_id + 1;
        if (avm_read[g]) read_high <= read_high + 1;
        if (avm_read[g] && !first_seen) begin
          first_seen <= 1'b1;
          first_addr <= avm_address[g];
        end
        if (prev_stall && (!avm_read[g] || avm_address[g] != prev_addr)) unstable <= 1'b1;
      end
    end
  end

  // One full check: trigger by reset release or start, then compare the run
  // against the outcome predicted from the words and stall length.
  task automatic run_case(input string name, input int stall, input logic [31:0] wid,
                          input logic [31:0] wts, input bit via_reset, input bit poke_start);
    int edges [N];
    bit seen  [N];
    bit ok, to;
    int attempts, exp_edges;
    stall_len = stall;
    word_id   = wid;
    word_ts   = wts;
    clr_stats = 1'b1;
    @(negedge clock);
    clr_stats = 1'b0;
    for (int g = 0; g < N; g++) begin
      edges[g] = -1;
      seen[g]  = 1'b0;
    end
    if (via_reset) reset_n = 1'b1;
    else           start   = 1'b1;
    for (int n = 1; n <= BUDGET && !(seen[0] && seen[1]); n++) begin
      @(negedge clock);
      start = 1'b0;
      for (int g = 0; g < N; g++) begin
        if (!seen[g] && done[g]) begin
          seen[g]  = 1'b1;
          edges[g] = n;
        end
      end
      if (n == 2) begin
        for (int g = 0; g < N; g++) check($sformatf("%s/u%0d/busy_mid", name, g), busy[g], 1);
        if (poke_start) start = 1'b1;
      end
    end
    ok       = (wid == EXP_ID) && (wts == EXP_TS);
    to       = (stall >= TIMEOUT);
    attempts = ok ? 1 : MAX_RETRIES + 1;
    for (int g = 0; g < N; g++) begin
      exp_edges = to ? (1 + TIMEOUT) : (attempts * (2 * (stall + 1 + 2 * g) + 1) + 1);
      if (!via_reset) exp_edges++;
      if (!to) begin
        cap_id[g] = wid;
        cap_ts[g] = wts;
      end
      check($sformatf("%s/u%0d/done_cycle", name, g), edges[g], exp_edges);
      check($sformatf("%s/u%0d/pass", name, g), pass[g], (ok && !to) ? 1 : 0);
      check($sformatf("%s/u%0d/timeout", name, g), timeout[g], to ? 1 : 0);
      check($sformatf("%s/u%0d/mismatch_id", name, g), mismatch_id[g],
            (!to && !ok && wid != EXP_ID) ? 1 : 0);
      check($sformatf("%s/u%0d/mismatch_ts", name, g), mismatch_ts[g],
            (!to && !ok && wts != EXP_TS) ? 1 : 0);
      check($sformatf("%s/u%0d/id_value", name, g), id_value[g], cap_id[g]);
      check($sformatf("%s/u%0d/ts_value", name, g), ts_value[g], cap_ts[g]);
      check($sformatf("%s/u%0d/reads_id", name, g), rd_id_a[g], to ? 0 : attempts);
      check($sformatf("%s/u%0d/reads_ts", name, g), rd_ts_a[g], to ? 0 : attempts);
      check($sformatf("%s/u%0d/read_cycles", name, g), read_high_a[g],
            to ? TIMEOUT : attempts * 2 * (stall + 1));
      check($sformatf("%s/u%0d/stall_stable", name, g), unstable_a[g], 0);
      check($sformatf("%s/u%0d/first_read_seen", name, g), first_seen_a[g], 1);
      check($sformatf("%s/u%0d/first_addr", name, g), first_addr_a[g], 0);
      check($sformatf("%s/u%0d/busy_done", name, g), busy[g], 0);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    for (int g = 0; g < N; g++) begin
      cap_id[g] = '0;
      cap_ts[g] = '0;
      check($sformatf("%s/u%0d/avm_read", name, g), avm_read[g], 0);
      check($sformatf("%s/u%0d/avm_address", name, g), avm_address[g], 0);
      check($sformatf("%s/u%0d/busy", name, g), busy[g], 0);
      check($sformatf("%s/u%0d/done", name, g), done[g], 0);
      check($sformatf("%s/u%0d/pass", name, g), pass[g], 0);
      check($sformatf("%s/u%0d/flags", name, g),
            {mismatch_id[g], mismatch_ts[g], timeout[g]}, 0);
      check($sformatf("%s/u%0d/id_value", name, g), id_value[g], 0);
      check($sformatf("%s/u%0d/ts_value", name, g), ts_value[g], 0);
    end
  endtask

  initial begin
    bit found;
    logic [31:0] wid, wts;
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");

    run_case("basic", 0, EXP_ID, EXP_TS, 1'b1, 1'b0);
    run_case("stall3", 3, EXP_ID, EXP_TS, 1'b0, 1'b0);
    run_case("bad_id", 0, 32'hDEAD_BEEF, EXP_TS, 1'b0, 1'b0);
    run_case("stuck", 100000, EXP_ID, EXP_TS, 1'b0, 1'b0);
    run_case("healthy", 1, EXP_ID, EXP_TS, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      wid = ($urandom_range(0, 2) == 0) ? 32'($urandom) : EXP_ID;
      wts = ($urandom_range(0, 2) == 0) ? 32'($urandom) : EXP_TS;
      run_case($sformatf("rand%0d", r), int'($urandom_range(0, 3)), wid, wts,
               1'b0, 1'($urandom_range(0, 1)));
    end

    // Abort a run while the timestamp read is on the bus.
    stall_len = 3;
    @(negedge clock);
    start = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clock);
      start = 1'b0;
      if (avm_read[0] && avm_address[0]) found = 1'b1;
    end
    check("midread/reached_rd_ts", found, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midread");
    run_case("after_reset", 2, EXP_ID, EXP_TS, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", tests, errors);
    $finish;
  end

endmodule
